// File: rtl/mem_bus_decoder_pkg.sv
// rtl/mem_bus_decoder_pkg.sv - shared types for the core data port bus decoder
//
// Purpose: write-size encoding carried on the master and slave sides of the bus.
package mem_bus_decoder_pkg;

  typedef enum logic [1:0] {
    MEM_W_SIZE_BYTE = 2'd0,
    MEM_W_SIZE_HALF = 2'd1,
    MEM_W_SIZE_WORD = 2'd2
  } mem_w_size_e;

endpackage

// File: rtl/mem_bus_decoder.sv
// rtl/mem_bus_decoder.sv - table-driven single-master to N-slave memory bus decoder
//
// Purpose: steers master requests to one of N_SLAVES slaves by the address region
// field, returns read data on the cycle after a read handshake, answers unmapped
// accesses with an error response, and breaks stalled accesses with a watchdog.
//
// Ports:
//   i_clk, i_rst                      clock, synchronous active-high reset
//   i_m_valid/i_m_w_en/i_m_addr/
//   i_m_w_data/i_m_w_size             master request
//   o_m_ready, o_m_r_data             master handshake and read data
//   o_s_valid[N_SLAVES]               per-slave request
//   o_s_w_en/o_s_addr/o_s_w_data/
//   o_s_w_size                        broadcast request fields (addr region bits zeroed)
//   i_s_ready[N_SLAVES], i_s_r_data   per-slave ready and packed read data
//   o_err                             pulse on an error transfer
//   o_err_sticky/o_err_addr/o_err_kind first captured error (kind 01 unmapped, 10 timeout)
//   i_err_clr                         clear captured error state
module mem_bus_decoder
  import mem_bus_decoder_pkg::*;
#(
  parameter int N_SLAVES       = 4,
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int DEC_MSB        = 31,
  parameter int DEC_LSB        = 28,
  parameter logic [DEC_MSB-DEC_LSB:0] SLAVE_REGION [N_SLAVES] = '{4'h1, 4'h8, 4'h9, 4'hA},
  parameter int TIMEOUT_CYCLES = 256,
  parameter logic [DATA_WIDTH-1:0] ERR_RDATA = 32'hDEADBEEF
) (
  input  logic                           i_clk,
  input  logic                           i_rst,
  input  logic                           i_m_valid,
  input  logic                           i_m_w_en,
  input  logic [ADDR_WIDTH-1:0]          i_m_addr,
  input  logic [DATA_WIDTH-1:0]          i_m_w_data,
  input  mem_w_size_e                    i_m_w_size,
  output logic                           o_m_ready,
  output logic [DATA_WIDTH-1:0]          o_m_r_data,
  output logic [N_SLAVES-1:0]            o_s_valid,
  output logic                           o_s_w_en,
  output logic [ADDR_WIDTH-1:0]          o_s_addr,
  output logic [DATA_WIDTH-1:0]          o_s_w_data,
  output mem_w_size_e                    o_s_w_size,
  input  logic [N_SLAVES-1:0]            i_s_ready,
  input  logic [N_SLAVES*DATA_WIDTH-1:0] i_s_r_data,
  output logic                           o_err,
  output logic                           o_err_sticky,
  output logic [ADDR_WIDTH-1:0]          o_err_addr,
  output logic [1:0]                     o_err_kind,
  input  logic                           i_err_clr
);

  localparam int RW = DEC_MSB - DEC_LSB + 1;
  localparam int SW = (N_SLAVES > 1) ? $clog2(N_SLAVES) : 1;
  localparam int CW = $clog2(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT_CYCLES - 1);

  localparam logic [1:0] KIND_UNMAPPED = 2'b01;
  localparam logic [1:0] KIND_TIMEOUT  = 2'b10;

  logic [RW-1:0] region;
  logic          any_hit;
  logic [SW-1:0] sel;
  logic [CW-1:0] stall_cnt;
  logic          timeout_fire;
  logic          handshake;
  logic          err_now;
  logic [1:0]    err_kind_now;
  logic          r_rd_pend;
  logic [SW-1:0] r_sel;
  logic          r_sel_err;

  assign region = i_m_addr[DEC_MSB:DEC_LSB];

  // Scan from the top down so the lowest matching index is the one left in sel.
  always_comb begin
    any_hit = 1'b0;
    sel     = '0;
    for (int i = N_SLAVES - 1; i >= 0; i--) begin
      if (region == SLAVE_REGION[i]) begin
        any_hit = 1'b1;
        sel     = SW'(i);
      end
    end
  end

  assign timeout_fire = i_m_valid && (stall_cnt == CNT_MAX);

  // Unmapped accesses complete immediately; a fired watchdog forces completion.
  assign o_m_ready    = any_hit ? (i_s_ready[sel] | timeout_fire) : 1'b1;
  assign handshake    = i_m_valid & o_m_ready;
  assign err_now      = i_m_valid & (~any_hit | timeout_fire);
  assign err_kind_now = any_hit ? KIND_TIMEOUT : KIND_UNMAPPED;
  assign o_err        = err_now;

  always_comb begin
    o_s_valid = '0;
    if (i_m_valid && any_hit && !timeout_fire) begin
      o_s_valid[sel] = 1'b1;
    end
  end

  assign o_s_w_en   = i_m_w_en;
  assign o_s_addr   = {{(ADDR_WIDTH - DEC_LSB){1'b0}}, i_m_addr[DEC_LSB-1:0]};
  assign o_s_w_data = i_m_w_data;
  assign o_s_w_size = i_m_w_size;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      stall_cnt <= '0;
    end else if (!i_m_valid || handshake) begin
      stall_cnt <= '0;
    end else if (stall_cnt != CNT_MAX) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

  // Steering state moves only on a read handshake, so a new request in the
  // data-return cycle cannot disturb the data being returned.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rd_pend <= 1'b0;
      r_sel     <= '0;
      r_sel_err <= 1'b0;
    end else begin
      r_rd_pend <= handshake & ~i_m_w_en;
      if (handshake && !i_m_w_en) begin
        r_sel     <= sel;
        r_sel_err <= ~any_hit | timeout_fire;
      end
    end
  end

  always_comb begin
    o_m_r_data = '0;
    if (r_rd_pend) begin
      o_m_r_data = r_sel_err ? ERR_RDATA
                             : i_s_r_data[int'(r_sel)*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // A clear in the same cycle as a new error re-arms capture for that error.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_err_sticky <= 1'b0;
      o_err_addr   <= '0;
      o_err_kind   <= 2'b00;
    end else if (err_now && (!o_err_sticky || i_err_clr)) begin
      o_err_sticky <= 1'b1;
      o_err_addr   <= i_m_addr;
      o_err_kind   <= err_kind_now;
    end else if (i_err_clr) begin
      o_err_sticky <= 1'b0;
      o_err_addr   <= '0;
      o_err_kind   <= 2'b00;
    end
  end

endmodule

// File: tb/tb_mem_bus_decoder.sv
// tb/tb_mem_bus_decoder.sv - self-checking bench for mem_bus_decoder
module tb_mem_bus_decoder;
  import mem_bus_decoder_pkg::*;

  logic          i_clk = 1'b0;
  logic          i_rst;
  logic          i_m_valid;
  logic          i_m_w_en;
  logic [31:0]   i_m_addr;
  logic [31:0]   i_m_w_data;
  mem_w_size_e   i_m_w_size;
  logic          o_m_ready;
  logic [31:0]   o_m_r_data;
  logic [3:0]    o_s_valid;
  logic          o_s_w_en;
  logic [31:0]   o_s_addr;
  logic [31:0]   o_s_w_data;
  mem_w_size_e   o_s_w_size;
  logic [3:0]    i_s_ready;
  logic [127:0]  i_s_r_data;
  logic          o_err;
  logic          o_err_sticky;
  logic [31:0]   o_err_addr;
  logic [1:0]    o_err_kind;
  logic          i_err_clr;

  int checks = 0;
  int failures = 0;

  mem_bus_decoder #(.TIMEOUT_CYCLES(8)) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_m_valid(i_m_valid), .i_m_w_en(i_m_w_en), .i_m_addr(i_m_addr),
    .i_m_w_data(i_m_w_data), .i_m_w_size(i_m_w_size),
    .o_m_ready(o_m_ready), .o_m_r_data(o_m_r_data),
    .o_s_valid(o_s_valid), .o_s_w_en(o_s_w_en), .o_s_addr(o_s_addr),
    .o_s_w_data(o_s_w_data), .o_s_w_size(o_s_w_size),
    .i_s_ready(i_s_ready), .i_s_r_data(i_s_r_data),
    .o_err(o_err), .o_err_sticky(o_err_sticky), .o_err_addr(o_err_addr),
    .o_err_kind(o_err_kind), .i_err_clr(i_err_clr)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic        valid;
    logic        w_en;
    logic [31:0] addr;
    logic [3:0]  s_ready;
    logic [3:0]  exp_s_valid;
    logic        exp_ready;
    logic [31:0] exp_s_addr;
    logic        exp_err;
  } vec_t;

  vec_t vecs [8];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  initial begin
    vecs[0] = '{1'b0, 1'b0, 32'h1000_0000, 4'hF, 4'b0000, 1'b1, 32'h0000_0000, 1'b0};
    vecs[1] = '{1'b1, 1'b0, 32'h1000_0010, 4'hF, 4'b0001, 1'b1, 32'h0000_0010, 1'b0};
    vecs[2] = '{1'b1, 1'b0, 32'h8ABC_DEF0, 4'h0, 4'b0010, 1'b0, 32'h0ABC_DEF0, 1'b0};
    vecs[3] = '{1'b1, 1'b1, 32'h9000_0004, 4'h4, 4'b0100, 1'b1, 32'h0000_0004, 1'b0};
    vecs[4] = '{1'b1, 1'b0, 32'hAFFF_FFFC, 4'h7, 4'b1000, 1'b0, 32'h0FFF_FFFC, 1'b0};
    vecs[5] = '{1'b1, 1'b1, 32'h5000_0000, 4'h0, 4'b0000, 1'b1, 32'h0000_0000, 1'b1};
    vecs[6] = '{1'b1, 1'b0, 32'hF123_4567, 4'hF, 4'b0000, 1'b1, 32'h0123_4567, 1'b1};
    vecs[7] = '{1'b1, 1'b0, 32'h0000_0000, 4'hF, 4'b0000, 1'b1, 32'h0000_0000, 1'b1};

    i_rst = 1'b1;
    i_m_valid = 1'b0;
    i_m_w_en = 1'b0;
    i_m_addr = '0;
    i_m_w_data = 32'hCAFE_F00D;
    i_m_w_size = MEM_W_SIZE_WORD;
    i_s_ready = 4'hF;
    i_s_r_data = {32'h0000_3333, 32'h0000_000B, 32'h0000_000A, 32'h0000_1234};
    i_err_clr = 1'b0;
    step();
    step();
    i_rst = 1'b0;

    check("reset_err", {63'd0, o_err}, 64'd0);
    check("reset_sticky", {63'd0, o_err_sticky}, 64'd0);
    check("reset_err_addr", {32'd0, o_err_addr}, 64'd0);
    check("reset_err_kind", {62'd0, o_err_kind}, 64'd0);
    check("reset_r_data", {32'd0, o_m_r_data}, 64'd0);
    check("reset_s_valid", {60'd0, o_s_valid}, 64'd0);

    // Combinational decode table.
    for (int i = 0; i < 8; i++) begin
      i_m_valid = vecs[i].valid;
      i_m_w_en  = vecs[i].w_en;
      i_m_addr  = vecs[i].addr;
      i_s_ready = vecs[i].s_ready;
      #1;
      check($sformatf("vec%0d_s_valid", i), {60'd0, o_s_valid}, {60'd0, vecs[i].exp_s_valid});
      check($sformatf("vec%0d_m_ready", i), {63'd0, o_m_ready}, {63'd0, vecs[i].exp_ready});
      check($sformatf("vec%0d_s_addr", i), {32'd0, o_s_addr}, {32'd0, vecs[i].exp_s_addr});
      check($sformatf("vec%0d_err", i), {63'd0, o_err}, {63'd0, vecs[i].exp_err});
      check($sformatf("vec%0d_s_w_en", i), {63'd0, o_s_w_en}, {63'd0, vecs[i].w_en});
      step();
    end

    i_m_valid = 1'b0;
    i_rst = 1'b1;
    step();
    i_rst = 1'b0;
    i_s_ready = 4'hF;
    check("rst2_sticky", {63'd0, o_err_sticky}, 64'd0);

    // Single read from slave 0.
    i_m_valid = 1'b1; i_m_w_en = 1'b0; i_m_addr = 32'h1000_0010;
    #1;
    check("rd0_s_valid", {60'd0, o_s_valid}, 64'b0001);
    check("rd0_s_addr", {32'd0, o_s_addr}, 64'h10);
    check("rd0_ready", {63'd0, o_m_ready}, 64'd1);
    step();
    i_m_valid = 1'b0;
    #1;
    check("rd0_r_data", {32'd0, o_m_r_data}, 64'h1234);
    step();
    check("rd0_idle_r_data", {32'd0, o_m_r_data}, 64'd0);

    // Back-to-back reads from slaves 1 and 2.
    i_m_valid = 1'b1; i_m_addr = 32'h8000_0000;
    step();
    i_m_addr = 32'h9000_0004;
    #1;
    check("b2b_first_r_data", {32'd0, o_m_r_data}, 64'hA);
    check("b2b_second_s_valid", {60'd0, o_s_valid}, 64'b0100);
    step();
    i_m_valid = 1'b0;
    #1;
    check("b2b_second_r_data", {32'd0, o_m_r_data}, 64'hB);
    step();

    // Unmapped write, then a second unmapped access.
    i_m_valid = 1'b1; i_m_w_en = 1'b1; i_m_addr = 32'h5000_0000; i_s_ready = 4'h0;
    #1;
    check("unm_ready", {63'd0, o_m_ready}, 64'd1);
    check("unm_s_valid", {60'd0, o_s_valid}, 64'd0);
    check("unm_err", {63'd0, o_err}, 64'd1);
    step();
    i_m_valid = 1'b0;
    #1;
    check("unm_err_pulse_end", {63'd0, o_err}, 64'd0);
    check("unm_sticky", {63'd0, o_err_sticky}, 64'd1);
    check("unm_err_addr", {32'd0, o_err_addr}, 64'h5000_0000);
    check("unm_err_kind", {62'd0, o_err_kind}, 64'b01);
    check("unm_write_no_r_data", {32'd0, o_m_r_data}, 64'd0);
    i_m_valid = 1'b1; i_m_addr = 32'h6000_0000;
    #1;
    check("unm2_err", {63'd0, o_err}, 64'd1);
    step();
    i_m_valid = 1'b0;
    check("unm2_err_addr_held", {32'd0, o_err_addr}, 64'h5000_0000);

    i_err_clr = 1'b1;
    step();
    i_err_clr = 1'b0;
    check("clr_sticky", {63'd0, o_err_sticky}, 64'd0);
    check("clr_err_addr", {32'd0, o_err_addr}, 64'd0);
    check("clr_err_kind", {62'd0, o_err_kind}, 64'd0);

    // Watchdog on slave 3 with ready held low.
    i_m_valid = 1'b1; i_m_w_en = 1'b0; i_m_addr = 32'hA000_0000; i_s_ready = 4'h0;
    for (int c = 1; c <= 7; c++) begin
      #1;
      check($sformatf("wd_stall%0d_ready", c), {63'd0, o_m_ready}, 64'd0);
      check($sformatf("wd_stall%0d_s_valid", c), {60'd0, o_s_valid}, 64'b1000);
      step();
    end
    check("wd_fire_ready", {63'd0, o_m_ready}, 64'd1);
    check("wd_fire_s_valid", {60'd0, o_s_valid}, 64'd0);
    check("wd_fire_err", {63'd0, o_err}, 64'd1);
    step();
    i_m_valid = 1'b0;
    #1;
    check("wd_r_data", {32'd0, o_m_r_data}, 64'hDEAD_BEEF);
    check("wd_err_kind", {62'd0, o_err_kind}, 64'b10);
    check("wd_err_addr", {32'd0, o_err_addr}, 64'hA000_0000);
    step();

    // Clear coinciding with a new unmapped error.
    i_err_clr = 1'b1; i_m_valid = 1'b1; i_m_w_en = 1'b1; i_m_addr = 32'h7000_0000;
    step();
    i_err_clr = 1'b0; i_m_valid = 1'b0;
    check("clr_new_sticky", {63'd0, o_err_sticky}, 64'd1);
    check("clr_new_err_addr", {32'd0, o_err_addr}, 64'h7000_0000);
    check("clr_new_err_kind", {62'd0, o_err_kind}, 64'b01);

    // Reset the cycle after a read handshake.
    i_s_ready = 4'hF; i_m_valid = 1'b1; i_m_w_en = 1'b0; i_m_addr = 32'h1000_0000;
    step();
    i_m_valid = 1'b0; i_rst = 1'b1;
    step();
    i_rst = 1'b0;
    check("rstmid_r_data", {32'd0, o_m_r_data}, 64'd0);
    check("rstmid_sticky", {63'd0, o_err_sticky}, 64'd0);
    check("rstmid_err_addr", {32'd0, o_err_addr}, 64'd0);
    check("rstmid_err_kind", {62'd0, o_err_kind}, 64'd0);
    check("rstmid_err", {63'd0, o_err}, 64'd0);
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
